// File: rtl/tt_um_acc_jellyant.sv
// ---------------------------------------------------------------------------
// tt_um_acc_jellyant -- byte-wide command accumulator with shift-add MAC
//
// Commands arrive as an opcode on uio_in[2:0] plus an operand on ui_in. They
// are qualified by an asynchronous strobe on uio_in[3], which is
// synchronised and edge-detected. An operation executes three clock edges
// after the first edge that samples the strobe high. MAC runs as an 8-cycle
// shift-add sequence, and busy is held high while it runs.
//
// Parameters
//   ACC_W    accumulator width in bits (8, 16, 24 or 32)
//
// Optional feature
//   ACC_SAT_EN  when defined, ADD and MAC steps that overflow clamp the
//               accumulator to all-ones, and a SUB that underflows clamps
//               it to zero. When undefined, all arithmetic wraps.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset
//   ena      in   power-good (ignored)
//   ui_in    in   [7:0] operand byte
//   uo_out   out  [7:0] accumulator byte selected by SEL (0 if out of range)
//   uio_in   in   [2:0] opcode, [3] strobe, [7:4] ignored
//   uio_out  out  [4] busy, [5] zero, [6] sticky overflow, [7] done pulse
//   uio_oe   out  constant 8'hF0
// ---------------------------------------------------------------------------
module tt_um_acc_jellyant #(
  parameter int ACC_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBYTES = ACC_W / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOADA = 3'b001;
  localparam logic [2:0] OP_LOADB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_MAC   = 3'b101;
  localparam logic [2:0] OP_SEL   = 3'b110;
  localparam logic [2:0] OP_CLR   = 3'b111;

  // ---------------------------------------------------------------------
  // Strobe synchroniser and rising-edge detector
  // ---------------------------------------------------------------------
  logic       sync1_q, sync2_q, sync3_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       accept_q;

  // The reset-cleared synchroniser flops look like a real low and would fake
  // an edge for a strobe that is already high at reset release. vld_q marks
  // when sync2_q holds a genuine sample. armed_q is set only after that
  // sample has been seen low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      sync1_q  <= uio_in[3];
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      vld_q    <= {vld_q[0], 1'b1};
      armed_q  <= armed_q | (vld_q[1] & ~sync2_q);
      accept_q <= sync2_q & ~sync3_q & armed_q;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       a_q, a_d;
  logic [1:0]       sel_q, sel_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       idx_q, idx_d;
  logic             done_q, done_d;
  state_t           state_q, state_d;

  logic [2:0] opcode;
  assign opcode = uio_in[2:0];

  // Arithmetic carries one extra bit so carry and borrow come for free.
  logic [ACC_W:0]   add_sum;
  logic [ACC_W:0]   sub_diff;
  logic [ACC_W+7:0] mac_term;
  logic [ACC_W+8:0] mac_sum;
  logic             add_carry, sub_borrow, mac_carry, mac_bit;

  assign add_sum    = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, ui_in};
  assign sub_diff   = {1'b0, acc_q} - {{(ACC_W-7){1'b0}}, ui_in};
  assign add_carry  = add_sum[ACC_W];
  assign sub_borrow = sub_diff[ACC_W];

  // b is shifted inside ACC_W+8 bits, so no partial-product bit is lost
  // before the overflow decision.
  assign mac_term  = {{ACC_W{1'b0}}, b_q} << idx_q;
  assign mac_sum   = {9'b0, acc_q} + {1'b0, mac_term};
  assign mac_carry = |mac_sum[ACC_W+8:ACC_W];
  assign mac_bit   = a_q[idx_q];

  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    a_d     = a_q;
    sel_d   = sel_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    state_d = state_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_q) begin
          case (opcode)
            OP_NOP:   ;
            OP_LOADA: acc_d = {{(ACC_W-8){1'b0}}, ui_in};
            OP_LOADB: b_d = ui_in;
            OP_ADD: begin
`ifdef ACC_SAT_EN
              acc_d = add_carry ? {ACC_W{1'b1}} : add_sum[ACC_W-1:0];
`else
              acc_d = add_sum[ACC_W-1:0];
`endif
              if (add_carry) ovf_d = 1'b1;
            end
            OP_SUB: begin
`ifdef ACC_SAT_EN
              acc_d = sub_borrow ? {ACC_W{1'b0}} : sub_diff[ACC_W-1:0];
`else
              acc_d = sub_diff[ACC_W-1:0];
`endif
              if (sub_borrow) ovf_d = 1'b1;
            end
            OP_MAC: begin
              a_d     = ui_in;
              idx_d   = 3'd0;
              state_d = ST_MAC;
            end
            OP_SEL: sel_d = ui_in[1:0];
            OP_CLR: begin
              acc_d = '0;
              ovf_d = 1'b0;
              sel_d = 2'd0;
            end
            default: ;
          endcase
        end
      end

      // Strobes accepted here are simply dropped: nothing is queued.
      ST_MAC: begin
        if (mac_bit) begin
`ifdef ACC_SAT_EN
          acc_d = mac_carry ? {ACC_W{1'b1}} : mac_sum[ACC_W-1:0];
`else
          acc_d = mac_sum[ACC_W-1:0];
`endif
          if (mac_carry) ovf_d = 1'b1;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      b_q     <= 8'd0;
      a_q     <= 8'd0;
      sel_q   <= 2'd0;
      ovf_q   <= 1'b0;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      acc_q   <= acc_d;
      b_q     <= b_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [7:0] acc_bytes [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    if (gi < NBYTES) begin : g_real
      assign acc_bytes[gi] = acc_q[gi*8 +: 8];
    end else begin : g_pad
      assign acc_bytes[gi] = 8'h00;
    end
  end

  assign uo_out  = acc_bytes[sel_q];
  assign uio_out = {done_q, ovf_q, (acc_q == '0), (state_q == ST_MAC), 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:4]};

endmodule
